// File: rtl/cl_axil_mst_pkg.sv
// Shared types and constants for the CL AXI-Lite register master.
package cl_axil_mst_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StRsp,
    StDrain
  } state_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEAD_DEAD;

endpackage

// File: rtl/cl_axil_mst_wdog.sv
// Response-wait watchdog: counts cycles while i_active, flags the last allowed cycle.
module cl_axil_mst_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  output logic o_expire
);

  logic [15:0] r_cnt;

  // Counter is held at zero outside the wait states, so entry always starts from 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_active) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expire = i_active && (r_cnt == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cl_ocl_axil_master.sv
// Single-outstanding AXI-Lite master for the CL register space.
// Optional response watchdog and drain path enabled by defining CL_AXIL_MST_TIMEOUT_EN.
module cl_ocl_axil_master
  import cl_axil_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_sync,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        busy,

  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  state_e      r_state;
  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rsp_valid;
  logic        r_rsp_wr;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;
  logic        r_rsp_timeout;
  logic        r_drain_pending;

  logic        w_aw_done;
  logic        w_w_done;
  logic        w_late_beat;
  logic        w_expire;

`ifdef CL_AXIL_MST_TIMEOUT_EN
  logic w_waiting;
  assign w_waiting = (r_state == StWrResp) || (r_state == StRdData);

  cl_axil_mst_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk   (clk_main_a0),
    .i_rst   (rst_main_sync),
    .i_active(w_waiting),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // AW and W complete independently; a channel is done once its valid has dropped.
  assign w_aw_done   = !r_awvalid || m_axi_awready;
  assign w_w_done    = !r_wvalid || m_axi_wready;
  assign w_late_beat = (r_bready && m_axi_bvalid) || (r_rready && m_axi_rvalid);

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      r_state         <= StIdle;
      r_cmd_ready     <= 1'b0;
      r_busy          <= 1'b0;
      r_wr            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_bready        <= 1'b0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_wr        <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_resp      <= '0;
      r_rsp_timeout   <= 1'b0;
      r_drain_pending <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_wr        <= cmd_wr;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            if (cmd_wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= StWrReq;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= StRdReq;
            end
          end
        end
        StWrReq: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= StWrResp;
          end
        end
        StWrResp: begin
          if (m_axi_bvalid) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_wr      <= r_wr;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= m_axi_bresp;
            r_rsp_timeout <= 1'b0;
            r_state       <= StRsp;
          end else if (w_expire) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_wr        <= r_wr;
            r_rsp_rdata     <= TIMEOUT_RDATA;
            r_rsp_resp      <= AXI_RESP_SLVERR;
            r_rsp_timeout   <= 1'b1;
            r_drain_pending <= 1'b1;
            r_state         <= StRsp;
          end
        end
        StRdReq: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdData;
          end
        end
        StRdData: begin
          if (m_axi_rvalid) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_wr      <= r_wr;
            r_rsp_rdata   <= m_axi_rdata;
            r_rsp_resp    <= m_axi_rresp;
            r_rsp_timeout <= 1'b0;
            r_state       <= StRsp;
          end else if (w_expire) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_wr        <= r_wr;
            r_rsp_rdata     <= TIMEOUT_RDATA;
            r_rsp_resp      <= AXI_RESP_SLVERR;
            r_rsp_timeout   <= 1'b1;
            r_drain_pending <= 1'b1;
            r_state         <= StRsp;
          end
        end
        StRsp: begin
          // A late beat of a timed-out transaction may already arrive here.
          if (r_drain_pending && w_late_beat) begin
            r_drain_pending <= 1'b0;
            r_bready        <= 1'b0;
            r_rready        <= 1'b0;
          end
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_drain_pending && !w_late_beat) begin
              r_state <= StDrain;
            end else begin
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= StIdle;
            end
          end
        end
        StDrain: begin
          if (w_late_beat) begin
            r_drain_pending <= 1'b0;
            r_bready        <= 1'b0;
            r_rready        <= 1'b0;
            r_busy          <= 1'b0;
            r_cmd_ready     <= 1'b1;
            r_state         <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign busy          = r_busy;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_wr        = r_rsp_wr;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_cl_ocl_axil_master.sv
// Directed bench for cl_ocl_axil_master with a delay-configurable AXI-Lite slave model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_cl_ocl_axil_master;
  import cl_axil_mst_pkg::*;

  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  cl_ocl_axil_master #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_main_a0  (clk),
    .rst_main_sync(rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_wr       (rsp_wr),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Slave model configuration and state
  int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic        aw_seen, w_seen, ar_seen;
  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int          n_aw, n_w, n_b, n_ar, n_r, n_unstable;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  logic [3:0]  got_wstrb;
  logic        p_awvalid, p_wvalid, p_arvalid;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic slave_clear();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_unstable = 0;
  endtask

  task automatic cfg_set(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] bresp, input logic [1:0] rresp,
                         input logic [31:0] rdata);
    cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b; cfg_ar_dly = ar; cfg_r_dly = r;
    cfg_bresp = bresp; cfg_rresp = rresp; cfg_rdata = rdata;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_unstable = 0;
  endtask

  task automatic slave_step();
    // Anything valid last falling edge without a handshake must still be there, unchanged.
    if (p_awvalid && !hs_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) n_unstable++;
    if (p_wvalid && !hs_w && (!m_axi_wvalid || m_axi_wdata != p_wdata)) n_unstable++;
    if (p_arvalid && !hs_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr)) n_unstable++;
    if (hs_aw) begin m_axi_awready = 0; aw_wait = 0; aw_seen = 1; n_aw++; end
    if (hs_w)  begin m_axi_wready = 0; w_wait = 0; w_seen = 1; n_w++; end
    if (hs_b)  begin m_axi_bvalid = 0; n_b++; end
    if (hs_ar) begin m_axi_arready = 0; ar_wait = 0; ar_seen = 1; n_ar++; end
    if (hs_r)  begin m_axi_rvalid = 0; n_r++; end
    if (m_axi_awvalid && !m_axi_awready) begin
      if (aw_wait >= cfg_aw_dly) m_axi_awready = 1; else aw_wait++;
    end
    if (m_axi_wvalid && !m_axi_wready) begin
      if (w_wait >= cfg_w_dly) m_axi_wready = 1; else w_wait++;
    end
    if (m_axi_arvalid && !m_axi_arready) begin
      if (ar_wait >= cfg_ar_dly) m_axi_arready = 1; else ar_wait++;
    end
    if (aw_seen && w_seen && !m_axi_bvalid) begin
      if (b_wait >= cfg_b_dly) begin
        m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; aw_seen = 0; w_seen = 0; b_wait = 0;
      end else b_wait++;
    end
    if (ar_seen && !m_axi_rvalid) begin
      if (r_wait >= cfg_r_dly) begin
        m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
        ar_seen = 0; r_wait = 0;
      end else r_wait++;
    end
    hs_aw = m_axi_awvalid && m_axi_awready;
    hs_w  = m_axi_wvalid && m_axi_wready;
    hs_b  = m_axi_bvalid && m_axi_bready;
    hs_ar = m_axi_arvalid && m_axi_arready;
    hs_r  = m_axi_rvalid && m_axi_rready;
    if (hs_aw) got_awaddr = m_axi_awaddr;
    if (hs_w) begin got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb; end
    if (hs_ar) got_araddr = m_axi_araddr;
    p_awvalid = m_axi_awvalid; p_awaddr = m_axi_awaddr;
    p_wvalid  = m_axi_wvalid;  p_wdata  = m_axi_wdata;
    p_arvalid = m_axi_arvalid; p_araddr = m_axi_araddr;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    slave_step();
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int t);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int i = 0; i < 200 && !cmd_ready; i++) tick();
    t = cyc;
    if (!cmd_ready) check("cmd_accept_bound", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int t);
    for (int i = 0; i < 200 && !rsp_valid; i++) tick();
    t = cyc;
    if (!rsp_valid) check("rsp_wait_bound", 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  int t_cmd, t_rsp, t_acc, extra;
  logic hold_ok;
  logic [31:0] snap_rdata;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    slave_clear();
    cfg_set(0, 0, 0, 0, 0, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0);
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'd0);
    check("rst_readies", {30'd0, m_axi_bready, m_axi_rready}, 32'd0);
    check("rst_rsp_payload", {rsp_rdata[31:4], rsp_resp, rsp_wr, rsp_timeout}, 32'd0);
    rst = 0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write, rsp_ready held high
    rsp_ready = 1;
    send_cmd(1'b1, 32'h0000_0500, 32'h1234_5678, 4'hF, t_cmd);
    check("wr_aw_at_t1", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    check("wr_busy", 32'(busy), 32'd1);
    wait_rsp(t_rsp);
    check("wr_latency", 32'(t_rsp - t_cmd), 32'd3);
    check("wr_awaddr", got_awaddr, 32'h0000_0500);
    check("wr_wdata", got_wdata, 32'h1234_5678);
    check("wr_wstrb", 32'(got_wstrb), 32'hF);
    check("wr_rsp_wr", 32'(rsp_wr), 32'd1);
    check("wr_rsp_resp", 32'(rsp_resp), 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check("wr_cmd_ready_t4", 32'(cmd_ready), 32'd1);
    check("wr_rsp_valid_off", 32'(rsp_valid), 32'd0);
    rsp_ready = 0;

    // Read with AR delayed 2 and data after 5 wait cycles
    cfg_set(0, 0, 0, 2, 5, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_BEEF);
    send_cmd(1'b0, 32'h0000_0504, 32'h0, 4'h0, t_cmd);
    check("rd_ar_at_t1", 32'(m_axi_arvalid), 32'd1);
    wait_rsp(t_rsp);
    check("rd_latency", 32'(t_rsp - t_cmd), 32'd10);
    check("rd_araddr", got_araddr, 32'h0000_0504);
    check("rd_rdata", rsp_rdata, 32'h0000_BEEF);
    check("rd_resp", 32'(rsp_resp), 32'd0);
    check("rd_rsp_wr", 32'(rsp_wr), 32'd0);
    check("rd_ar_stable", 32'(n_unstable), 32'd0);
    consume();

    // W accepted 4 cycles after AW, slave answers SLVERR
    cfg_set(0, 4, 0, 0, 0, 2'b10, AXI_RESP_OKAY, 32'h0);
    send_cmd(1'b1, 32'h0000_0508, 32'hCAFE_0001, 4'h5, t_cmd);
    wait_rsp(t_rsp);
    check("wdly_latency", 32'(t_rsp - t_cmd), 32'd7);
    check("wdly_w_stable", 32'(n_unstable), 32'd0);
    check("wdly_wdata", got_wdata, 32'hCAFE_0001);
    check("wdly_wstrb", 32'(got_wstrb), 32'h5);
    check("wdly_resp", 32'(rsp_resp), 32'd2);
    consume();
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) extra++;
      tick();
    end
    check("wdly_one_b", 32'(n_b), 32'd1);
    check("wdly_one_rsp", 32'(extra), 32'd0);

    // rsp_ready low for 10 cycles with a second command waiting
    cfg_set(0, 0, 0, 0, 0, AXI_RESP_OKAY, 2'b01, 32'hA5A5_0001);
    send_cmd(1'b0, 32'h0000_050C, 32'h0, 4'h0, t_cmd);
    wait_rsp(t_rsp);
    snap_rdata = rsp_rdata;
    check("bp_rdata", snap_rdata, 32'hA5A5_0001);
    check("bp_resp", 32'(rsp_resp), 32'd1);
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h0000_0510; cmd_wdata = 32'h0BAD_F00D;
    cmd_wstrb = 4'h3;
    hold_ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_rdata != snap_rdata || rsp_resp != 2'b01 || cmd_ready) hold_ok = 0;
      tick();
    end
    check("bp_hold", 32'(hold_ok), 32'd1);
    rsp_ready = 1;
    check("bp_cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
    tick();
    rsp_ready = 0;
    check("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    t_acc = cyc;
    tick();
    cmd_valid = 0;
    check("bp_second_aw", 32'(m_axi_awvalid), 32'd1);
    wait_rsp(t_rsp);
    check("bp_second_latency", 32'(t_rsp - t_acc), 32'd3);
    check("bp_second_wdata", got_wdata, 32'h0BAD_F00D);
    check("bp_second_rsp_wr", 32'(rsp_wr), 32'd1);
    consume();

    // Read whose data arrives 20 cycles into the wait
    cfg_set(0, 0, 0, 0, 20, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_1234);
    rsp_ready = 1;
    send_cmd(1'b0, 32'h0000_0520, 32'h0, 4'h0, t_cmd);
    wait_rsp(t_rsp);
`ifdef CL_AXIL_MST_TIMEOUT_EN
    check("to_latency", 32'(t_rsp - t_cmd), 32'd18);
    check("to_resp", 32'(rsp_resp), 32'd2);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_rdata", rsp_rdata, 32'hDEAD_DEAD);
    tick();
    extra = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      if (rsp_valid) extra++;
      tick();
    end
    check("to_drained_busy", 32'(busy), 32'd0);
    check("to_drained_beat", 32'(n_r), 32'd1);
    check("to_no_extra_rsp", 32'(extra), 32'd0);
    check("to_rready_off", 32'(m_axi_rready), 32'd0);
    check("to_cmd_ready", 32'(cmd_ready), 32'd1);
`else
    check("slow_latency", 32'(t_rsp - t_cmd), 32'd23);
    check("slow_rdata", rsp_rdata, 32'h0000_1234);
    check("slow_no_timeout", 32'(rsp_timeout), 32'd0);
    tick();
`endif
    rsp_ready = 0;

    // Reset while waiting for B
    cfg_set(0, 0, 50, 0, 0, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0);
    send_cmd(1'b1, 32'h0000_0530, 32'h5555_AAAA, 4'hF, t_cmd);
    for (int i = 0; i < 20 && !m_axi_bready; i++) tick();
    check("rstmid_in_wr_resp", 32'(m_axi_bready), 32'd1);
    rst = 1;
    tick();
    check("rstmid_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_bready", 32'(m_axi_bready), 32'd0);
    rst = 0;
    slave_clear();
    tick();
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) extra++;
      tick();
    end
    check("rstmid_no_rsp", 32'(extra), 32'd0);

    // Recovery read carrying an SLVERR from the slave
    cfg_set(0, 0, 0, 0, 0, AXI_RESP_OKAY, 2'b10, 32'hCAFE_F00D);
    send_cmd(1'b0, 32'h0000_0600, 32'h0, 4'h0, t_cmd);
    wait_rsp(t_rsp);
    check("rec_latency", 32'(t_rsp - t_cmd), 32'd3);
    check("rec_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("rec_resp", 32'(rsp_resp), 32'd2);
    consume();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
